// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Purpose  : Four-way signal phase sequencer. Rotates service among the
//            north/east/south/west roads, announces the served road on
//            next_road, sizes each green interval from that road's sensor
//            average, skips roads with an empty queue, and drives one-hot
//            green/yellow lamps.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous, active-low reset
//            hold       - freezes the green countdown while high in GREEN
//            avg_north/east/south/west [7:0] - sensor averages, unsigned
//            next_road  [1:0] - served road (0=N, 1=E, 2=S, 3=W), registered
//            green      [3:0] - one-hot green lamp, bit index = road code
//            yellow     [3:0] - one-hot yellow lamp, bit index = road code
//            phase      [1:0] - 0=LOAD, 1=GREEN, 2=YELLOW, 3=ALL_RED
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 60,
  parameter int SCALE_SHIFT = 1,
  parameter int YELLOW_TIME = 3,
  parameter int RED_TIME    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [7:0] avg_north,
  input  logic [7:0] avg_east,
  input  logic [7:0] avg_south,
  input  logic [7:0] avg_west,
  output logic [1:0] next_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_t;

  localparam logic [16:0] c_MIN_GREEN   = 17'(MIN_GREEN);
  localparam logic [16:0] c_MAX_GREEN   = 17'(MAX_GREEN);
  localparam logic [15:0] c_YELLOW_TIME = 16'(YELLOW_TIME);
  localparam logic [15:0] c_RED_TIME    = 16'(RED_TIME);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_glen, w_glen_nxt;
  logic [1:0]  r_road, w_road_nxt;
  logic [3:0]  r_green, w_green_nxt;
  logic [3:0]  r_yellow, w_yellow_nxt;

  logic [7:0]  w_avg_cur;
  logic [16:0] w_sum;
  logic [15:0] w_g;
  logic [1:0]  w_c1, w_c2, w_c3;
  logic [7:0]  w_avg_c1, w_avg_c2, w_avg_c3;
  logic [1:0]  w_sel;

  function automatic logic [7:0] pick_avg(input logic [1:0] code,
                                          input logic [7:0] a0,
                                          input logic [7:0] a1,
                                          input logic [7:0] a2,
                                          input logic [7:0] a3);
    case (code)
      2'd0:    pick_avg = a0;
      2'd1:    pick_avg = a1;
      2'd2:    pick_avg = a2;
      default: pick_avg = a3;
    endcase
  endfunction

  // Green length: 17-bit sum so MIN_GREEN near 65535 plus a scaled average
  // cannot wrap before the clamp.
  assign w_avg_cur = pick_avg(r_road, avg_north, avg_east, avg_south, avg_west);
  assign w_sum     = c_MIN_GREEN + ({9'd0, w_avg_cur} >> SCALE_SHIFT);
  assign w_g       = (w_sum > c_MAX_GREEN) ? c_MAX_GREEN[15:0] : w_sum[15:0];

  // Next-road scan: candidates in rotation order, current road excluded, so
  // next_road always changes and every sensor sees an update edge.
  assign w_c1     = r_road + 2'd1;
  assign w_c2     = r_road + 2'd2;
  assign w_c3     = r_road + 2'd3;
  assign w_avg_c1 = pick_avg(w_c1, avg_north, avg_east, avg_south, avg_west);
  assign w_avg_c2 = pick_avg(w_c2, avg_north, avg_east, avg_south, avg_west);
  assign w_avg_c3 = pick_avg(w_c3, avg_north, avg_east, avg_south, avg_west);

  always_comb begin
    w_sel = w_c1;
    if (w_avg_c1 != 8'd0)      w_sel = w_c1;
    else if (w_avg_c2 != 8'd0) w_sel = w_c2;
    else if (w_avg_c3 != 8'd0) w_sel = w_c3;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_glen_nxt  = r_glen;
    w_road_nxt  = r_road;
    case (r_state)
      ST_LOAD: begin
        // One cycle here gives the sensor's avg time to settle after the
        // next_road change before it is sampled.
        w_glen_nxt  = w_g;
        w_cnt_nxt   = w_g;
        w_state_nxt = ST_GREEN;
      end
      ST_GREEN: begin
        if (!hold) begin
          if (r_cnt <= 16'd1) begin
            w_state_nxt = ST_YELLOW;
            w_cnt_nxt   = c_YELLOW_TIME;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
      end
      ST_YELLOW: begin
        if (r_cnt <= 16'd1) begin
          w_state_nxt = ST_ALL_RED;
          w_cnt_nxt   = c_RED_TIME;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_ALL_RED: begin
        if (r_cnt <= 16'd1) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = 16'd0;
          w_road_nxt  = w_sel;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase

    // Lamps are registered from the next state; the road never changes on
    // entry to GREEN or YELLOW, so r_road is the lit road.
    w_green_nxt  = 4'd0;
    w_yellow_nxt = 4'd0;
    if (w_state_nxt == ST_GREEN)  w_green_nxt  = 4'd1 << r_road;
    if (w_state_nxt == ST_YELLOW) w_yellow_nxt = 4'd1 << r_road;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_LOAD;
      r_cnt    <= 16'd0;
      r_glen   <= 16'd0;
      r_road   <= 2'd0;
      r_green  <= 4'd0;
      r_yellow <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_glen   <= w_glen_nxt;
      r_road   <= w_road_nxt;
      r_green  <= w_green_nxt;
      r_yellow <= w_yellow_nxt;
    end
  end

  assign next_road = r_road;
  assign green     = r_green;
  assign yellow    = r_yellow;
  assign phase     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_controller
// Purpose  : Self-checking bench for traffic_phase_controller. Each table
//            record describes one service (LOAD..ALL_RED) of a road: the
//            averages presented, hold activity, expected green length and
//            the road selected next.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic [7:0] avg [4];
  logic [1:0] next_road;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  traffic_phase_controller dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .avg_north (avg[0]),
    .avg_east  (avg[1]),
    .avg_south (avg[2]),
    .avg_west  (avg[3]),
    .next_road (next_road),
    .green     (green),
    .yellow    (yellow),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a_n, a_e, a_s, a_w;
    int         hs;    // first green cycle with hold high (-1 = none)
    int         hl;    // number of held green cycles
    bit         hy;    // hold high throughout yellow
    bit         poke;  // change served road's avg mid-green
    logic [1:0] road;
    int         g;     // expected green cycles
    logic [1:0] nxt;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic [7:0] n, e, s, w, input int hs, hl,
                              input bit hy, poke, input logic [1:0] road,
                              input int g, input logic [1:0] nxt);
    vec_t v;
    v.a_n = n; v.a_e = e; v.a_s = s; v.a_w = w;
    v.hs = hs; v.hl = hl; v.hy = hy; v.poke = poke;
    v.road = road; v.g = g; v.nxt = nxt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at a negedge where phase is LOAD; returns at the next LOAD.
  task automatic run_service(input vec_t v, input string name);
    int n;
    avg[0] = v.a_n; avg[1] = v.a_e; avg[2] = v.a_s; avg[3] = v.a_w;
    hold = 1'b0;
    chk({name, " load_phase"}, phase, 0);
    chk({name, " load_road"}, next_road, v.road);
    chk({name, " load_lamps"}, {green, yellow}, 0);
    @(negedge clk);
    n = 0;
    while (phase == 2'd1 && n < 300) begin
      hold = (v.hs >= 0 && n >= v.hs && n < v.hs + v.hl);
      if (v.poke && n == 2) avg[v.road] = 8'd255;
      chk({name, " green_lamps"}, {green, yellow}, {4'd1 << v.road, 4'd0});
      @(negedge clk);
      n++;
    end
    chk({name, " green_len"}, n, v.g);
    hold = v.hy;
    n = 0;
    while (phase == 2'd2 && n < 50) begin
      chk({name, " yellow_lamps"}, {green, yellow}, {4'd0, 4'd1 << v.road});
      @(negedge clk);
      n++;
    end
    hold = 1'b0;
    chk({name, " yellow_len"}, n, 3);
    n = 0;
    while (phase == 2'd3 && n < 50) begin
      chk({name, " red_lamps"}, {green, yellow}, 0);
      @(negedge clk);
      n++;
    end
    chk({name, " red_len"}, n, 2);
    chk({name, " next_phase"}, phase, 0);
    chk({name, " next_road"}, next_road, v.nxt);
  endtask

  initial begin
    int n;
    //              N    E    S    W   hs  hl hy pk road  g nxt
    vecs[0]  = mk(20,  20,  20,  20, -1,  0, 0, 0, 0, 20, 1); // default period 26
    vecs[1]  = mk(20, 255,  20,  20, -1,  0, 0, 0, 1, 60, 2); // saturation
    vecs[2]  = mk(20,   0,   0,  20, -1,  0, 0, 0, 2, 10, 3); // minimum
    vecs[3]  = mk( 7,   0,   0,  20, -1,  0, 0, 0, 3, 20, 0);
    vecs[4]  = mk( 7,   0,   0,   5, -1,  0, 0, 0, 0, 13, 3); // skip E,S
    vecs[5]  = mk( 0,   0,   0,   0, -1,  0, 0, 0, 3, 10, 0); // all empty
    vecs[6]  = mk( 0,   0,   0,   0, -1,  0, 0, 0, 0, 10, 1);
    vecs[7]  = mk( 0,   0,   0,   0, -1,  0, 0, 0, 1, 10, 2);
    vecs[8]  = mk( 0,   0,   0,   0, -1,  0, 0, 0, 2, 10, 3);
    vecs[9]  = mk( 0,   0,   0,   0, -1,  0, 0, 0, 3, 10, 0);
    vecs[10] = mk( 1,   0,   9,   4, -1,  0, 0, 0, 0, 10, 2); // scan order
    vecs[11] = mk(20,  20,  20,  20,  5,  7, 1, 0, 2, 27, 3); // hold 7, yellow hold
    vecs[12] = mk(20,  20,  20,  20, 19,  3, 0, 0, 3, 23, 0); // hold on last green
    vecs[13] = mk(20,  20,  20,  20, -1,  0, 0, 1, 0, 20, 1); // mid-green avg change
    vecs[14] = mk(20,  20,  20,  20, -1,  0, 0, 0, 1, 20, 2);

    reset = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < 4; i++) avg[i] = 8'd20;
    repeat (3) @(negedge clk);
    chk("reset_phase", phase, 0);
    chk("reset_road", next_road, 0);
    chk("reset_lamps", {green, yellow}, 0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) run_service(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-YELLOW while serving road 2.
    n = 0;
    while (phase != 2'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midyel_reached", phase, 2);
    chk("midyel_road", next_road, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("midyel_rst_road", next_road, 0);
    chk("midyel_rst_phase", phase, 0);
    chk("midyel_rst_green", green, 0);
    chk("midyel_rst_yellow", yellow, 0);
    reset = 1'b1;

    // Sensor loopback: the south sensor shifts in 40 when next_road goes
    // 1->2, moving its average from 20 to 25; green becomes 10+(25>>1)=22.
    run_service(mk(20, 20, 20, 20, -1, 0, 0, 0, 0, 20, 1), "loop0");
    run_service(mk(20, 20, 20, 20, -1, 0, 0, 0, 1, 20, 2), "loop1");
    run_service(mk(20, 20, 25, 20, -1, 0, 0, 0, 2, 22, 3), "loop2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
